notation_serial: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).

---
 rtl/notation_serial.sv | 119 +++++++++++
 tb/tb_notation_serial.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/notation_serial.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// A conversion takes WIDTH+1 cycles from the accepting edge to the done pulse.
// The digits output holds the last complete result and never shows partial values.
module notation_serial #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Reject parameter sets whose largest input cannot be represented in DIGITS.
    if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_digits_check
        $error("notation_serial: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH-1:0]      r_shift;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [4*DIGITS-1:0]   w_adj;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DIGITS-1:0]   r_digits;

    assign busy   = r_busy;
    assign done   = r_done;
    assign digits = r_digits;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: idle until start, WIDTH shift cycles, one finish cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_SHIFT) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add 3 to every scratch digit of 5 or more ahead of this cycle's shift.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath: load on start, shift {scratch, shift_reg} left, publish on finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_digits <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= number;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    r_digits <= r_bcd;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_notation_serial.sv
// Self-checking bench for notation_serial: a transaction-level model predicts
// busy/done/digits every cycle; directed phases pin the model with literals.
module tb_notation_serial;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    number;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] digits;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    notation_serial #(
        .WIDTH (WIDTH),
        .DIGITS(DIGITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .number(number),
        .busy  (busy),
        .done  (done),
        .digits(digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a conversion in flight, its operand and its age in edges.
    bit                  m_busy;
    bit                  m_done;
    int unsigned         m_val;
    int unsigned         m_age;
    logic [4*DIGITS-1:0] m_digits;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_val    = 0;
            m_age    = 0;
            m_digits = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_age++;
                if (m_age == WIDTH + 1) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_digits = to_bcd(m_val);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_val  = number;
                m_age  = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("digits", 32'(digits), 32'(m_digits));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Advance until done is seen; an expired bound is a failure.
    task automatic wait_done(input int max_cycles, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        automatic int bc;
        automatic int ndone;
        automatic int gap;
        rst    = 1'b0;
        start  = 1'b0;
        number = '0;

        // Asynchronous reset with no clock edge involved.
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_digits", 32'(digits), 32'h000);
        cmp_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Maximum value, single-cycle start.
        number = 8'd255;
        start  = 1'b1;
        step();
        start  = 1'b0;
        number = 8'd17;
        wait_done(30, bc);
        chk("max_busy_cycles", 32'(bc + 1), 32'd9);
        chk("max_digits", 32'(digits), 32'h255);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("max_digits_hold", 32'(digits), 32'h255);

        // Zero, single-digit and a carry into the hundreds.
        number = 8'd0;   start = 1'b1; step(); start = 1'b0;
        wait_done(30, bc);
        chk("zero_digits", 32'(digits), 32'h000);
        number = 8'd9;   start = 1'b1; step(); start = 1'b0;
        wait_done(30, bc);
        chk("nine_digits", 32'(digits), 32'h009);
        number = 8'd100; start = 1'b1; step(); start = 1'b0;
        wait_done(30, bc);
        chk("hundred_digits", 32'(digits), 32'h100);
        step();

        // Start held high: start during busy is not queued; dones are periodic.
        number = 8'd42;
        start  = 1'b1;
        wait_done(30, bc);
        chk("held_digits", 32'(digits), 32'h042);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            ndone = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (done) begin
                    ndone = 1;
                    break;
                end
                gap++;
            end
            chk("held_done_seen", 32'(ndone), 32'd1);
            chk("held_done_gap", 32'(gap), 32'd9);
            chk("held_digits_rep", 32'(digits), 32'h042);
        end
        start = 1'b0;
        step();
        step();

        // Reset mid-conversion aborts with no done afterwards.
        number = 8'd200;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_digits", 32'(digits), 32'h000);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Exhaustive sweep, each conversion started in the previous done cycle.
        number = 8'd0;
        start  = 1'b1;
        for (int n = 0; n < 256; n++) begin
            wait_done(30, bc);
            chk("sweep_digits", 32'(digits), 32'(to_bcd(n)));
            if (n < 255) number = 8'(n + 1);
        end
        start = 1'b0;
        step();
        step();

        // Random traffic with occasional resets, checked by the model each cycle.
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            number = 8'($urandom);
            rst    = ($urandom_range(0, 99) == 0);
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
